// File: rtl/video_sync_decoder.sv
// Recovers raster coordinates and data enable from incoming hsync/vsync/de and
// tracks lock against the expected timing, counting every timing mismatch.
module video_sync_decoder #(
   parameter int ACTIVE_H_PIXELS = 1280,
   parameter int H_FRONT_PORCH   = 110,
   parameter int H_SYNCH_WIDTH   = 40,
   parameter int H_BACK_PORCH    = 220,
   parameter int ACTIVE_LINES    = 720,
   parameter int V_FRONT_PORCH   = 5,
   parameter int V_SYNCH_WIDTH   = 5,
   parameter int V_BACK_PORCH    = 20,
   parameter int LOCK_FRAMES     = 2,
   localparam int H_TOTAL  = ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNCH_WIDTH + H_BACK_PORCH,
   localparam int V_TOTAL  = ACTIVE_LINES + V_FRONT_PORCH + V_SYNCH_WIDTH + V_BACK_PORCH,
   localparam int HS_START = ACTIVE_H_PIXELS + H_FRONT_PORCH,
   localparam int VS_START = ACTIVE_LINES + V_FRONT_PORCH,
   localparam int SXW      = $clog2(H_TOTAL),
   localparam int SYW      = $clog2(V_TOTAL)
) (
   input  logic           i_clk_pxl,
   input  logic           i_reset,
   input  logic           i_hsync,
   input  logic           i_vsync,
   input  logic           i_de,
   output logic [SXW-1:0] o_sx,
   output logic [SYW-1:0] o_sy,
   output logic           o_de,
   output logic           o_nf,
   output logic           o_locked,
   output logic           o_err,
   output logic [7:0]     o_err_cnt
);

   localparam int FOW = $clog2(LOCK_FRAMES + 1);

   localparam logic [SXW-1:0] SX_LAST    = SXW'(H_TOTAL - 1);
   localparam logic [SYW-1:0] SY_LAST    = SYW'(V_TOTAL - 1);
   localparam logic [SXW-1:0] HS_START_X = SXW'(HS_START);
   localparam logic [SYW-1:0] VS_START_Y = SYW'(VS_START);
   localparam logic [SXW-1:0] ACT_H_X    = SXW'(ACTIVE_H_PIXELS);
   localparam logic [SYW-1:0] ACT_V_Y    = SYW'(ACTIVE_LINES);
   localparam logic [FOW-1:0] LOCK_CNT   = FOW'(LOCK_FRAMES);

   typedef enum logic [1:0] {
      ST_UNLOCKED  = 2'd0,
      ST_H_ALIGNED = 2'd1,
      ST_V_ALIGNED = 2'd2,
      ST_LOCKED    = 2'd3
   } state_t;

   state_t         state_r, state_next_s;
   logic [FOW-1:0] frame_ok_r, frame_ok_next_s, frame_ok_inc_s;
   logic           hs_q_r, vs_q_r;
   logic           hs_rise_s, vs_rise_s;
   logic [SXW-1:0] sx_next_s, sx_load_s;
   logic [SYW-1:0] sy_next_s, sy_load_s;
   logic           origin_s, h_mis_s, v_mis_s, de_mis_s, mis_s;

   // Free-running coordinate prediction and sync-edge realignment
   always_comb begin
      hs_rise_s = i_hsync & ~hs_q_r;
      vs_rise_s = i_vsync & ~vs_q_r;
      sx_next_s = (o_sx == SX_LAST) ? SXW'(0) : o_sx + SXW'(1);
      if (o_sx == SX_LAST) begin
         sy_next_s = (o_sy == SY_LAST) ? SYW'(0) : o_sy + SYW'(1);
      end else begin
         sy_next_s = o_sy;
      end
      sx_load_s = hs_rise_s ? HS_START_X : sx_next_s;
      sy_load_s = vs_rise_s ? VS_START_Y : sy_next_s;
      origin_s  = (sx_next_s == SXW'(0)) && (sy_next_s == SYW'(0));
      h_mis_s   = hs_rise_s ^ (sx_next_s == HS_START_X);
      v_mis_s   = vs_rise_s ^ ((sx_next_s == SXW'(0)) && (sy_next_s == VS_START_Y));
      de_mis_s  = i_de ^ ((sx_next_s < ACT_H_X) && (sy_next_s < ACT_V_Y));
   end

   // Lock FSM: next state, frame counter and mismatch qualification
   always_comb begin
      state_next_s    = state_r;
      frame_ok_next_s = frame_ok_r;
      frame_ok_inc_s  = frame_ok_r + FOW'(1);
      mis_s           = 1'b0;
      case (state_r)
         ST_UNLOCKED: begin
            if (hs_rise_s) begin
               state_next_s = ST_H_ALIGNED;
            end else begin
               state_next_s = ST_UNLOCKED;
            end
         end
         ST_H_ALIGNED: begin
            mis_s = h_mis_s;
            if (h_mis_s) begin
               state_next_s = ST_UNLOCKED;
            end else if (vs_rise_s) begin
               state_next_s    = ST_V_ALIGNED;
               frame_ok_next_s = FOW'(0);
            end else begin
               state_next_s = ST_H_ALIGNED;
            end
         end
         ST_V_ALIGNED: begin
            mis_s = h_mis_s | v_mis_s | de_mis_s;
            // A mismatch pre-empts the frame count on the same cycle
            if (mis_s) begin
               state_next_s = ST_UNLOCKED;
            end else if (origin_s) begin
               frame_ok_next_s = frame_ok_inc_s;
               state_next_s    = (frame_ok_inc_s >= LOCK_CNT) ? ST_LOCKED : ST_V_ALIGNED;
            end else begin
               state_next_s = ST_V_ALIGNED;
            end
         end
         ST_LOCKED: begin
            mis_s = h_mis_s | v_mis_s | de_mis_s;
            if (mis_s) begin
               state_next_s = ST_UNLOCKED;
            end else begin
               state_next_s = ST_LOCKED;
            end
         end
         default: begin
            state_next_s    = ST_UNLOCKED;
            frame_ok_next_s = FOW'(0);
         end
      endcase
   end

   // State, coordinate and output registers; reset wins over everything
   always_ff @(posedge i_clk_pxl) begin
      if (i_reset) begin
         state_r    <= ST_UNLOCKED;
         frame_ok_r <= FOW'(0);
         hs_q_r     <= 1'b1;
         vs_q_r     <= 1'b1;
         o_sx       <= SXW'(0);
         o_sy       <= SYW'(0);
         o_de       <= 1'b0;
         o_nf       <= 1'b0;
         o_locked   <= 1'b0;
         o_err      <= 1'b0;
         o_err_cnt  <= 8'd0;
      end else begin
         state_r    <= state_next_s;
         frame_ok_r <= frame_ok_next_s;
         hs_q_r     <= i_hsync;
         vs_q_r     <= i_vsync;
         o_sx       <= sx_load_s;
         o_sy       <= sy_load_s;
         o_locked   <= (state_next_s == ST_LOCKED);
         o_de       <= (state_next_s == ST_LOCKED) && (sx_load_s < ACT_H_X) && (sy_load_s < ACT_V_Y);
         o_nf       <= (state_next_s == ST_LOCKED) && (sx_load_s == SXW'(0)) && (sy_load_s == SYW'(0));
         o_err      <= mis_s;
         o_err_cnt  <= (mis_s && (o_err_cnt != 8'hFF)) ? o_err_cnt + 8'd1 : o_err_cnt;
      end
   end

endmodule

// File: tb/tb_video_sync_decoder.sv
// Bench for video_sync_decoder on a reduced 28x13 raster: acquisition, locked
// tracking via a scoreboard, a table of fault scenarios and counter saturation.
module tb_video_sync_decoder;
   localparam int AH = 16, HFP = 4, HSW = 3, HBP = 5;
   localparam int AL = 6, VFP = 2, VSW = 2, VBP = 3;
   localparam int LF = 2;
   localparam int HT = AH + HFP + HSW + HBP;
   localparam int VT = AL + VFP + VSW + VBP;
   localparam int HSS = AH + HFP;
   localparam int VSS = AL + VFP;
   localparam int FR = HT * VT;
   localparam int SXW = $clog2(HT);
   localparam int SYW = $clog2(VT);

   localparam int K_NONE = 0, K_DE = 1, K_HS_LATE = 2, K_VS_MISS = 3, K_HS_EXTRA = 4, K_RST = 5;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           hs = 1'b0, vs = 1'b0, de = 1'b0;
   logic [SXW-1:0] sx;
   logic [SYW-1:0] sy;
   logic           ode, onf, locked, err;
   logic [7:0]     cnt;

   video_sync_decoder #(
      .ACTIVE_H_PIXELS(AH), .H_FRONT_PORCH(HFP), .H_SYNCH_WIDTH(HSW), .H_BACK_PORCH(HBP),
      .ACTIVE_LINES(AL), .V_FRONT_PORCH(VFP), .V_SYNCH_WIDTH(VSW), .V_BACK_PORCH(VBP),
      .LOCK_FRAMES(LF)
   ) dut (
      .i_clk_pxl(clk), .i_reset(rst), .i_hsync(hs), .i_vsync(vs), .i_de(de),
      .o_sx(sx), .o_sy(sy), .o_de(ode), .o_nf(onf), .o_locked(locked),
      .o_err(err), .o_err_cnt(cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int sx;
      int sy;
      int de;
      int nf;
   } exp_t;

   typedef struct {
      string name;
      int    kind;
      int    fsx;
      int    fsy;
      int    cnt_fault;
      int    pulses;
      int    zz;
      int    cnt_end;
   } rec_t;

   exp_t sb[$];
   rec_t recs[5];
   int   checks = 0, failures = 0;
   int   gsx = 0, gsy = 0, last_sx = 0, last_sy = 0;
   bit   chk_en = 1'b0;
   int   f_kind = K_NONE, f_sx = 0, f_sy = 0;
   bit   f_on = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (after sample sx=%0d sy=%0d)",
                  name, act, exp, last_sx, last_sy);
      end
   endtask

   // One raster sample: drive generator timing (with any armed fault), then check
   task automatic cycle();
      bit   h, v, d, d_ideal, r, at_pt;
      exp_t e;
      if (gsx == 0 && gsy == 0 && f_on) begin
         f_on   = 1'b0;
         f_kind = K_NONE;
      end
      at_pt = (gsx == f_sx) && (gsy == f_sy);
      if (f_kind != K_NONE && !f_on && at_pt) f_on = 1'b1;
      h = (gsx >= HSS) && (gsx < HSS + HSW);
      v = (gsy >= VSS) && (gsy < VSS + VSW);
      d_ideal = (gsx < AH) && (gsy < AL);
      d = d_ideal;
      r = 1'b0;
      if (f_on) begin
         case (f_kind)
            K_DE:       if (at_pt) d = 1'b0;
            K_HS_LATE:  if (gsy == f_sy) h = (gsx >= HSS + 3) && (gsx < HSS + 3 + HSW);
            K_VS_MISS:  v = 1'b0;
            K_HS_EXTRA: if (at_pt) h = 1'b1;
            K_RST:      if (at_pt) r = 1'b1;
            default:    ;
         endcase
      end
      hs = h; vs = v; de = d; rst = r;
      e.sx = gsx; e.sy = gsy; e.de = int'(d_ideal); e.nf = int'(gsx == 0 && gsy == 0);
      sb.push_back(e);
      last_sx = gsx; last_sy = gsy;
      gsx = (gsx == HT - 1) ? 0 : gsx + 1;
      if (gsx == 0) gsy = (gsy == VT - 1) ? 0 : gsy + 1;
      @(posedge clk); #1;
      e = sb.pop_front();
      if (chk_en) begin
         check("trk_sx", int'(sx), e.sx);
         check("trk_sy", int'(sy), e.sy);
         check("trk_de", int'(ode), e.de);
         check("trk_nf", int'(onf), e.nf);
         check("trk_err", int'(err), 0);
         check("trk_locked", int'(locked), 1);
      end
   endtask

   initial begin
      int lock_k, nf_count;

      recs[0] = '{name: "de_drop",    kind: K_DE,       fsx: 10,  fsy: 2,   cnt_fault: 1, pulses: 1, zz: 2, cnt_end: 1};
      recs[1] = '{name: "hs_late",    kind: K_HS_LATE,  fsx: HSS, fsy: 3,   cnt_fault: 2, pulses: 2, zz: 2, cnt_end: 3};
      recs[2] = '{name: "vs_missing", kind: K_VS_MISS,  fsx: 0,   fsy: VSS, cnt_fault: 4, pulses: 1, zz: 3, cnt_end: 4};
      recs[3] = '{name: "hs_extra",   kind: K_HS_EXTRA, fsx: 5,   fsy: 1,   cnt_fault: 5, pulses: 1, zz: 2, cnt_end: 5};
      recs[4] = '{name: "rst_pulse",  kind: K_RST,      fsx: 5,   fsy: 1,   cnt_fault: 0, pulses: 0, zz: 2, cnt_end: 0};

      // Reset values
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_sx", int'(sx), 0);
      check("rst_sy", int'(sy), 0);
      check("rst_de", int'(ode), 0);
      check("rst_nf", int'(onf), 0);
      check("rst_locked", int'(locked), 0);
      check("rst_err", int'(err), 0);
      check("rst_cnt", int'(cnt), 0);

      // Acquisition from a reset released at generator (0,0)
      lock_k = -1;
      for (int k = 0; k < 4 * FR && lock_k < 0; k++) begin
         cycle();
         if (last_sx == HSS && last_sy == 0 && k < HT) check("acq_hs_load", int'(sx), HSS);
         check("acq_err", int'(err), 0);
         if (locked) lock_k = k;
      end
      check("acq_lock_cycle", lock_k, 2 * FR);

      // One full locked frame against the delayed generator
      chk_en = 1'b1;
      nf_count = 0;
      for (int k = 0; k < FR; k++) begin
         cycle();
         nf_count += int'(onf);
      end
      chk_en = 1'b0;
      check("nf_per_frame", nf_count, 1);

      // Fault scenarios, each starting from lock and ending with re-lock
      foreach (recs[r]) begin
         int pulses, zz, lk, waited;
         f_kind = recs[r].kind;
         f_sx   = recs[r].fsx;
         f_sy   = recs[r].fsy;
         waited = 0;
         while (!(gsx == f_sx && gsy == f_sy) && waited < 2 * FR) begin
            cycle();
            waited++;
         end
         check({recs[r].name, "_pre_locked"}, int'(locked), 1);
         cycle();
         check({recs[r].name, "_err"}, int'(err), (recs[r].kind == K_RST) ? 0 : 1);
         check({recs[r].name, "_unlock"}, int'(locked), 0);
         check({recs[r].name, "_cnt"}, int'(cnt), recs[r].cnt_fault);
         if (recs[r].kind == K_RST) begin
            check("rst_pulse_sx", int'(sx), 0);
            check("rst_pulse_sy", int'(sy), 0);
         end
         pulses = int'(err);
         zz = 0;
         lk = -1;
         for (int k = 0; k < 5 * FR && lk < 0; k++) begin
            cycle();
            pulses += int'(err);
            if (last_sx == 0 && last_sy == 0) zz++;
            if (locked) lk = k;
            if (recs[r].kind == K_HS_LATE && zz == 0 && last_sy == f_sy && last_sx == HSS + 3) begin
               check("hs_late_shift_err", int'(err), 0);
               check("hs_late_shift_sx", int'(sx), HSS);
               check("hs_late_shift_cnt", int'(cnt), recs[r].cnt_fault);
            end
         end
         check({recs[r].name, "_relock"}, int'(lk >= 0), 1);
         check({recs[r].name, "_relock_frames"}, zz, recs[r].zz);
         check({recs[r].name, "_pulses"}, pulses, recs[r].pulses);
         check({recs[r].name, "_cnt_end"}, int'(cnt), recs[r].cnt_end);
      end

      // Error counter saturation: alternate hsync rises, every second one mismatches
      rst = 1'b1; hs = 1'b0; vs = 1'b0; de = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 1200; i++) begin
         hs = ((i % 2) == 0);
         @(posedge clk); #1;
         if (i == 399) check("sat_mid_cnt", int'(cnt), 100);
         if (i == 1198) check("sat_err_pulse", int'(err), 1);
      end
      check("sat_final_cnt", int'(cnt), 255);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/video_sync_decoder.md
VIDEO_SYNC_DECODER -- requirements
Module: video_sync_decoder

Interface
REQ-001 Parameter ACTIVE_H_PIXELS, default 1280, active pixels per line.
REQ-002 Parameters H_FRONT_PORCH, H_SYNCH_WIDTH, H_BACK_PORCH, defaults 110, 40, 220; H_TOTAL = sum of all four horizontal parameters = 1650.
REQ-003 Parameter ACTIVE_LINES, default 720, active lines per frame.
REQ-004 Parameters V_FRONT_PORCH, V_SYNCH_WIDTH, V_BACK_PORCH, defaults 5, 5, 20; V_TOTAL = sum of all four vertical parameters = 750.
REQ-005 Parameter LOCK_FRAMES, default 2, number of clean frames required before lock.
REQ-006 Derived constants: HS_START = ACTIVE_H_PIXELS+H_FRONT_PORCH (1390); VS_START = ACTIVE_LINES+V_FRONT_PORCH (725); SXW = $clog2(H_TOTAL) (11); SYW = $clog2(V_TOTAL) (10).
REQ-007 i_clk_pxl  in  1  pixel clock; the block has exactly one clock, and all state changes on its rising edge.
REQ-008 i_reset  in  1  reset; synchronous, active-high.
REQ-009 i_hsync  in  1  horizontal sync, active-high; high for sx in [HS_START, HS_START+H_SYNCH_WIDTH-1].
REQ-010 i_vsync  in  1  vertical sync, active-high; rises at sx=0 of line VS_START.
REQ-011 i_de  in  1  data enable; high when sx<ACTIVE_H_PIXELS and sy<ACTIVE_LINES.
REQ-012 o_sx  out  SXW  recovered horizontal position.
REQ-013 o_sy  out  SYW  recovered vertical position.
REQ-014 o_de  out  1  recovered data enable; high = o_locked && o_sx<ACTIVE_H_PIXELS && o_sy<ACTIVE_LINES.
REQ-015 o_nf  out  1  new-frame pulse; high while o_locked && o_sx==0 && o_sy==0.
REQ-016 o_locked  out  1  high in state LOCKED only.
REQ-017 o_err  out  1  one-cycle pulse for each timing mismatch.
REQ-018 o_err_cnt  out  8  mismatch count; saturates at 255.

Function
REQ-019 Registers hs_q and vs_q hold the previous-cycle i_hsync and i_vsync; a rising edge is defined as i_x && !x_q.
REQ-020 sx_next = (o_sx==H_TOTAL-1) ? 0 : o_sx+1; sy_next increments (wrapping at V_TOTAL-1 to 0) only when o_sx==H_TOTAL-1, and otherwise holds.
REQ-021 Coordinate load rules, applied every cycle:
- o_sx loads HS_START on an hsync rising edge, otherwise loads sx_next.
- o_sy loads VS_START on a vsync rising edge, otherwise loads sy_next.
REQ-022 Latency is 1 cycle: o_sx and o_sy in cycle t+1 give the coordinates of the sync and de sample taken in cycle t.
REQ-023 The FSM states are UNLOCKED, H_ALIGNED, V_ALIGNED and LOCKED.
REQ-024 An h-mismatch is (hsync rising edge) XOR (sx_next==HS_START); it is evaluated in states H_ALIGNED, V_ALIGNED and LOCKED.
REQ-025 A v-mismatch is (vsync rising edge) XOR (sx_next==0 && sy_next==VS_START); it is evaluated in states V_ALIGNED and LOCKED.
REQ-026 A de-mismatch is i_de XOR (sx_next<ACTIVE_H_PIXELS && sy_next<ACTIVE_LINES); it is evaluated in states V_ALIGNED and LOCKED.
REQ-027 UNLOCKED moves to H_ALIGNED on an hsync rising edge; all mismatches are ignored in UNLOCKED.
REQ-028 H_ALIGNED transitions:
- moves to V_ALIGNED on a vsync rising edge with no h-mismatch, clearing frame_ok to 0;
- moves to UNLOCKED on an h-mismatch.
REQ-029 V_ALIGNED increments frame_ok each cycle in which sx_next==0 && sy_next==0 and there is no mismatch; it moves to LOCKED when frame_ok reaches LOCK_FRAMES.
REQ-030 LOCKED holds until a mismatch occurs.
REQ-031 Any mismatch in H_ALIGNED, V_ALIGNED or LOCKED produces all of the following:
- o_err pulses high on the next cycle;
- o_err_cnt increments by 1;
- the FSM moves to UNLOCKED.
The coordinate load still applies in that cycle.
REQ-032 When a mismatch and a frame_ok increment occur in the same cycle, the mismatch wins: no increment.
REQ-033 A missing expected edge counts as a mismatch exactly like an unexpected edge does.

Reset
REQ-034 i_reset has priority over all other events in the same cycle.
REQ-035 Reset values:
- state UNLOCKED; frame_ok=0;
- o_sx=0, o_sy=0, o_de=0, o_nf=0, o_locked=0, o_err=0, o_err_cnt=0;
- hs_q=1 and vs_q=1, so a sync already high at release is not detected as an edge.
REQ-036 Reset asserted mid-frame while LOCKED drops o_locked to 0 on the next cycle, and re-lock requires the full UNLOCKED sequence.

Verification
REQ-037 Clean 1280x720 stream from Video_Signal_Generator timing, reset released at its sx=0, sy=0 -> the following must all hold:
- hsync rise at sx=1390 gives o_sx=1390 one cycle later;
- vsync rise at line 725 moves the FSM to V_ALIGNED;
- o_locked rises one cycle after the second (0,0) point.
REQ-038 Once locked -> o_sx/o_sy equal the generator sx/sy delayed by 1 cycle for a full frame (1650x750 cycles); o_de matches the delayed de; o_nf pulses exactly once per frame; o_err never pulses.
REQ-039 While LOCKED, hsync rise shifted 3 cycles late on one line -> o_err pulses once at the expected-edge cycle and o_locked falls; o_err_cnt=1; the second pulse at the shifted edge is ignored because the FSM is already UNLOCKED.
REQ-040 While LOCKED, de forced low for 1 cycle at sx=100, sy=50 -> o_err pulses; o_err_cnt increments; the block re-locks after the next vsync plus 2 frames.
REQ-041 i_reset pulsed for 1 cycle while LOCKED at sx=500 -> next cycle o_sx=0, o_sy=0, o_locked=0, o_err_cnt=0; no o_err pulse results.
REQ-042 Force 300 hsync mismatches -> o_err_cnt saturates at 255 and does not wrap.
